interp_seq: RTL and testbench

INTERP_SEQ -- requirements
Module: interp_seq

---
 rtl/interp_seq.sv | 262 ++++++++++++++++++++++++++
 tb/tb_interp_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_seq.sv
// interp_seq: piecewise-linear table lookup sequencer.
//
// Holds NPTS (x,y) breakpoints. An accepted request walks the table one
// segment per cycle. The walk ends in one of three ways:
//   - the request clamps low, answered with Y[0];
//   - the request clamps high, answered with Y[NPTS-1];
//   - a bracketing segment is found. Its endpoints are handed to an
//     external linear interpolator, and the result is returned.
//
// Optional build macro INTERP_TIMEOUT_EN: bounds the wait for the
// interpolator to TIMEOUT cycles. On expiry an error response is returned
// with resp_y = 0. Without the macro the wait is unbounded and resp_err is
// tied low.
//
// Handshake contract:
//   - A request transfers on a rising edge where req_valid and req_ready are
//     both high. req_ready is high only while idle, with no table write
//     pending, and outside reset.
//   - resp_valid is a single-cycle strobe with no back-pressure.
//   - li_start is a single-cycle strobe. The li_* operands are held until
//     the next launch.
//   - li_done is honoured only while waiting for the interpolator.
//
// dbg_state exposes the FSM state for checkers.

module interp_seq #(
  parameter int NPTS    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  // breakpoint table load
  input  logic        tbl_we,
  input  logic [3:0]  tbl_addr,
  input  logic [13:0] tbl_x,
  input  logic [13:0] tbl_y,
  // lookup request
  input  logic        req_valid,
  input  logic [13:0] req_x,
  output logic        req_ready,
  // lookup result
  output logic        resp_valid,
  output logic [13:0] resp_y,
  output logic        resp_err,
  // external linear interpolator
  output logic        li_start,
  output logic [13:0] li_x,
  output logic [13:0] li_x0,
  output logic [13:0] li_y0,
  output logic [13:0] li_x1,
  output logic [13:0] li_y1,
  input  logic [13:0] li_y,
  input  logic        li_done,
  // debug visibility of the FSM
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEARCH = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Last segment index the walk may test, and last breakpoint index.
  localparam logic [3:0] J_LAST   = 4'(NPTS - 2);
  localparam logic [3:0] LAST_IDX = 4'(NPTS - 1);
  // Table depth widened so the write-address range check compares like widths.
  localparam logic [4:0] NPTS_W   = 5'(NPTS);

  state_t state;
  state_t state_nxt;

  // Storage is always 16 deep so a 4-bit index never overruns. Only the
  // first NPTS entries are ever written or read.
  logic [13:0] x_tbl [16];
  logic [13:0] y_tbl [16];

  logic [13:0] req_x_q;    // captured request abscissa
  logic [3:0]  j_q;        // segment currently under test
  logic [3:0]  j_nxt;

  logic        accept;     // request transfers this cycle
  logic        tbl_wr_ok;  // table write takes effect this cycle
  logic        hit_low;
  logic        hit_seg;
  logic        hit_high;
  logic        to_hit;     // interpolator wait expired this cycle

  assign j_nxt     = j_q + 4'd1;
  assign accept    = (state == S_IDLE) && req_valid && !tbl_we && !rst;
  assign tbl_wr_ok = (state == S_IDLE) && tbl_we && ({1'b0, tbl_addr} < NPTS_W);

  // Search decision for the current walk step.
  // The low-clamp test only applies on the first step. The segment test is
  // a strict less-than against the upper breakpoint, so x == X[k] lands in
  // segment k. The first step that matches wins, which also defines the
  // behaviour for non-ascending table contents.
  always_comb begin
    hit_low  = 1'b0;
    hit_seg  = 1'b0;
    hit_high = 1'b0;
    if ((j_q == 4'd0) && (req_x_q < x_tbl[0])) begin
      hit_low = 1'b1;
    end else if (req_x_q < x_tbl[j_nxt]) begin
      hit_seg = 1'b1;
    end else if (j_q == J_LAST) begin
      hit_high = 1'b1;
    end
  end

`ifdef INTERP_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wait_cnt;   // WAIT cycles elapsed since the launch

  // Expiry fires on the TIMEOUT-th WAIT cycle in which li_done is still absent.
  assign to_hit = (state == S_WAIT) && !li_done && (wait_cnt == TO_LAST);

  // Wait counter: cleared at launch, advanced on every WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Error flag: set on the cycle that enters RESP, then held until the
  // next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err <= 1'b0;
    end else if ((state == S_SEARCH) && (hit_low || hit_high)) begin
      resp_err <= 1'b0;
    end else if (state == S_WAIT) begin
      if (li_done) begin
        resp_err <= 1'b0;
      end else if (to_hit) begin
        resp_err <= 1'b1;
      end
    end
  end
`else
  logic [15:0] unused_timeout;

  assign to_hit         = 1'b0;
  assign resp_err       = 1'b0;
  assign unused_timeout = 16'(TIMEOUT);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (hit_low || hit_high) begin
          state_nxt = S_RESP;
        end else if (hit_seg) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (li_done || to_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    req_ready  = (state == S_IDLE) && !tbl_we && !rst;
    resp_valid = (state == S_RESP);
    li_start   = (state == S_LAUNCH);
    dbg_state  = state;
  end

  // Request capture, walk index, interpolator operands and result register.
  // The operands load when the bracketing segment is found, so they are
  // already valid during the launch cycle and stay put through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_x_q <= '0;
      j_q     <= '0;
      li_x    <= '0;
      li_x0   <= '0;
      li_y0   <= '0;
      li_x1   <= '0;
      li_y1   <= '0;
      resp_y  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_x_q <= req_x;
            j_q     <= 4'd0;
          end
        end
        S_SEARCH: begin
          if (hit_low) begin
            resp_y <= y_tbl[0];
          end else if (hit_seg) begin
            li_x  <= req_x_q;
            li_x0 <= x_tbl[j_q];
            li_y0 <= y_tbl[j_q];
            li_x1 <= x_tbl[j_nxt];
            li_y1 <= y_tbl[j_nxt];
          end else if (hit_high) begin
            resp_y <= y_tbl[LAST_IDX];
          end else begin
            j_q <= j_nxt;
          end
        end
        S_WAIT: begin
          if (li_done) begin
            resp_y <= li_y;
          end else if (to_hit) begin
            resp_y <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Breakpoint table: written only while idle, and kept across reset.
  always_ff @(posedge clk) begin
    if (tbl_wr_ok) begin
      x_tbl[tbl_addr] <= tbl_x;
      y_tbl[tbl_addr] <= tbl_y;
    end
  end

endmodule

// File: tb/tb_interp_seq.sv
// tb_interp_seq: randomized scoreboard bench for interp_seq.
// Build with +define+INTERP_TIMEOUT_EN to include the timeout scenario.

module tb_interp_seq;

  localparam int NPTS    = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbl_we;
  logic [3:0]  tbl_addr;
  logic [13:0] tbl_x;
  logic [13:0] tbl_y;
  logic        req_valid;
  logic [13:0] req_x;
  logic        req_ready;
  logic        resp_valid;
  logic [13:0] resp_y;
  logic        resp_err;
  logic        li_start;
  logic [13:0] li_x;
  logic [13:0] li_x0;
  logic [13:0] li_y0;
  logic [13:0] li_x1;
  logic [13:0] li_y1;
  logic [13:0] li_y;
  logic        li_done;
  logic [2:0]  dbg_state;

  interp_seq #(.NPTS(NPTS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_x(tbl_x), .tbl_y(tbl_y),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_y(resp_y), .resp_err(resp_err),
    .li_start(li_start), .li_x(li_x), .li_x0(li_x0), .li_y0(li_y0),
    .li_x1(li_x1), .li_y1(li_y1), .li_y(li_y), .li_done(li_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model state ----------------
  int mx [NPTS];
  int my [NPTS];

  // exp_q entry: [46] err, [45:32] y, [31:0] cycle in which resp_valid is due
  logic [46:0]  exp_q[$];
  // op_q entry: [101:88] x, [87:74] x0, [73:60] y0, [59:46] x1, [45:32] y1,
  //             [31:0] cycle in which li_start is due
  logic [101:0] op_q[$];

  int total = 0;
  int bad   = 0;

  int          li_delay = 3;
  bit          li_never = 0;
  bit          li_pend  = 0;
  int          li_wait  = 0;
  logic [13:0] li_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [13:0] interp_val(input int x, input int x0, input int y0,
                                             input int x1, input int y1);
    int v;
    if (x1 == x0) v = y0;
    else v = y0 + ((x - x0) * (y1 - y0)) / (x1 - x0);
    return 14'(v);
  endfunction

  // Expected outcome of a lookup accepted in cycle t, straight from the
  // table rules: low clamp, first bracketing segment, or high clamp.
  task automatic push_exp(input int x, input int t);
    int s;
    s = -1;
    if (x < mx[0]) begin
      exp_q.push_back({1'b0, 14'(my[0]), 32'(t + 2)});
    end else begin
      for (int k = 0; k < NPTS - 1; k++) begin
        if (x < mx[k + 1]) begin
          s = k;
          break;
        end
      end
      if (s < 0) begin
        exp_q.push_back({1'b0, 14'(my[NPTS - 1]), 32'(t + NPTS)});
      end else begin
        op_q.push_back({14'(x), 14'(mx[s]), 14'(my[s]), 14'(mx[s + 1]), 14'(my[s + 1]),
                        32'(t + 2 + s)});
        if (li_never)
          exp_q.push_back({1'b1, 14'd0, 32'(t + 3 + s + TIMEOUT)});
        else
          exp_q.push_back({1'b0, interp_val(x, mx[s], my[s], mx[s + 1], my[s + 1]),
                           32'(t + 2 + s + li_delay + 1)});
      end
    end
  endtask

  // ---------------- interpolator model ----------------
  always @(negedge clk) begin
    li_done = 1'b0;
    if (li_pend) begin
      li_wait--;
      if (li_wait == 0) begin
        li_done = 1'b1;
        li_y    = li_val;
        li_pend = 0;
      end
    end
    if (li_start && !rst && !li_never) begin
      li_pend = 1;
      li_wait = li_delay;
      li_val  = interp_val(int'(li_x), int'(li_x0), int'(li_y0), int'(li_x1), int'(li_y1));
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [101:0] o;
    logic [46:0]  e;
    if (!rst) begin
      if (li_start) begin
        if (op_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_li_start: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          o = op_q.pop_front();
          chk("li_x",   32'(li_x),  32'(o[101:88]));
          chk("li_x0",  32'(li_x0), 32'(o[87:74]));
          chk("li_y0",  32'(li_y0), 32'(o[73:60]));
          chk("li_x1",  32'(li_x1), 32'(o[59:46]));
          chk("li_y1",  32'(li_y1), 32'(o[45:32]));
          chk("li_start_cycle", 32'(cyc), o[31:0]);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got resp_y=%0d expected no response (cycle %0d)",
                   resp_y, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("resp_y",     32'(resp_y),   32'(e[45:32]));
          chk("resp_err",   32'(resp_err), 32'(e[46]));
          chk("resp_cycle", 32'(cyc),      e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tbl_write(input int addr, input int x, input int y, input bit upd);
    @(negedge clk);
    tbl_we   = 1'b1;
    tbl_addr = 4'(addr);
    tbl_x    = 14'(x);
    tbl_y    = 14'(y);
    @(negedge clk);
    tbl_we = 1'b0;
    if (upd && addr < NPTS) begin
      mx[addr] = x;
      my[addr] = y;
    end
  endtask

  task automatic do_req(input int x, input int d);
    bit acc;
    acc      = 0;
    li_delay = d;
    @(negedge clk);
    req_valid = 1'b1;
    req_x     = 14'(x);
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready) begin
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    chk("req_accepted", 32'(acc), 32'd1);
    if (acc) push_exp(x, cyc);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("resp_arrived", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    op_q.delete();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nresp;
    int x;
    rst = 1'b1;
    tbl_we = 1'b0; tbl_addr = '0; tbl_x = '0; tbl_y = '0;
    req_valid = 1'b0; req_x = '0;
    li_done = 1'b0; li_y = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_y",     32'(resp_y),     32'd0);
    chk("rst_resp_err",   32'(resp_err),   32'd0);
    chk("rst_li_start",   32'(li_start),   32'd0);
    chk("rst_li_x",       32'(li_x),       32'd0);
    chk("rst_li_x0",      32'(li_x0),      32'd0);
    chk("rst_li_y0",      32'(li_y0),      32'd0);
    chk("rst_li_x1",      32'(li_x1),      32'd0);
    chk("rst_li_y1",      32'(li_y1),      32'd0);
    rst = 1'b0;

    // common table X=100..800, Y=50..400
    for (int i = 0; i < NPTS; i++) tbl_write(i, 100 * (i + 1), 50 * (i + 1), 1);

    // directed lookups: interior, clamps, breakpoint equality, extremes
    do_req(250, 3);   wait_idle();
    do_req(50, 3);    wait_idle();
    do_req(800, 3);   wait_idle();
    do_req(100, 3);   wait_idle();
    do_req(799, 3);   wait_idle();
    do_req(0, 3);     wait_idle();
    do_req(16383, 3); wait_idle();

    // write during SEARCH is ignored
    do_req(300, 3);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 4'd2; tbl_x = 14'd350; tbl_y = 14'd7;
    @(negedge clk);
    tbl_we = 1'b0;
    wait_idle();
    do_req(300, 3); wait_idle();

    // out-of-range address is ignored
    tbl_write(8, 5000, 5, 0);
    do_req(150, 3); wait_idle();

    // write and request together: write wins, request goes next cycle
    li_delay = 3;
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 4'd3; tbl_x = 14'd400; tbl_y = 14'd1000;
    req_valid = 1'b1; req_x = 14'd350;
    #1;
    chk("ready_during_write", 32'(req_ready), 32'd0);
    @(negedge clk);
    tbl_we = 1'b0;
    my[3] = 1000;
    #1;
    chk("ready_after_write", 32'(req_ready), 32'd1);
    if (req_ready) push_exp(350, cyc);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_idle();

    // reset while waiting on the interpolator; the late li_done is ignored
    do_req(250, 12);
    for (int i = 0; i < 20; i++) begin
      if (op_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_resp_y",    32'(resp_y),    32'd0);
    chk("midrst_li_x0",     32'(li_x0),     32'd0);
    chk("midrst_li_start",  32'(li_start),  32'd0);
    rst = 1'b0;
    nresp = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("no_resp_after_rst", 32'(nresp), 32'd0);
    // table survives reset
    do_req(250, 3); wait_idle();

`ifdef INTERP_TIMEOUT_EN
    li_never = 1;
    do_req(250, 3); wait_idle();
    li_never = 0;
    do_req(450, 2); wait_idle();
`endif

    // randomized tables and requests
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NPTS; i++)
        tbl_write(i, i * 2000 + $urandom_range(0, 1999), $urandom_range(0, 16383), 1);
      for (int n = 0; n < 15; n++) begin
        case ($urandom_range(0, 3))
          0: x = $urandom_range(0, 16383);
          1: x = mx[$urandom_range(0, NPTS - 1)];
          2: x = $urandom_range(0, mx[0]);
          default: x = $urandom_range(mx[NPTS - 1], 16383);
        endcase
        do_req(x, $urandom_range(1, 6));
        wait_idle();
      end
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("op_q_drained",  32'(op_q.size()),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
